// File: rtl/aes_gcm_stage1_seq.sv
// aes_gcm_stage1_seq: GCM input stage emitting J0, AAD, PT and length blocks with counter blocks.
// Optional GCM_PARTIAL_MASK_EN masks and zeroes the unused bytes of a final partial AAD/PT block.
module aes_gcm_stage1_seq #(
    parameter int BLK_W = 128,
    parameter int KEY_W = 128,
    parameter int IV_W  = 96,
    parameter int LEN_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_new_instance,
    output logic               o_hdr_ready,
    input  logic [KEY_W-1:0]   i_cipher_key,
    input  logic [IV_W-1:0]    i_iv,
    input  logic [LEN_W-1:0]   i_aad_len,
    input  logic [LEN_W-1:0]   i_pt_len,
    input  logic               i_blk_valid,
    output logic               o_blk_ready,
    input  logic [BLK_W-1:0]   i_blk_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2:0]         o_phase,
    output logic [BLK_W-1:0]   o_data,
    output logic [BLK_W-1:0]   o_ctr,
    output logic [BLK_W/8-1:0] o_blk_mask,
    output logic [KEY_W-1:0]   o_key,
    output logic               o_last
);
    localparam int CTR_W = BLK_W - IV_W;
    localparam int NB    = BLK_W / 8;
    localparam int LOG   = $clog2(BLK_W);

    typedef enum logic [2:0] {IDLE = 3'd0, J0 = 3'd1, AAD = 3'd2, PT = 3'd3, LEN = 3'd4} state_t;

    state_t            state, state_n;
    logic [IV_W-1:0]   iv_q;
    logic [LEN_W-1:0]  aad_len_q, pt_len_q, rem, aad_n, pt_n;
    logic [CTR_W-1:0]  ctr;
    logic              load, hdr_acc, blk_acc, emit, last;
    logic [NB-1:0]     blk_mask;
    logic [BLK_W-1:0]  blk_data;

    function automatic logic [LEN_W-1:0] nblk(input logic [LEN_W-1:0] len);
        return (len >> LOG) + LEN_W'(|len[LOG-1:0]);
    endfunction

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_comb begin
        load        = !o_valid || i_ready;
        o_hdr_ready = state == IDLE && !o_valid;
        o_blk_ready = (state == AAD || state == PT) && load;
        hdr_acc     = o_hdr_ready && i_new_instance;
        blk_acc     = o_blk_ready && i_blk_valid;
        emit        = (state == J0 || state == LEN) ? load : blk_acc;
        aad_n       = nblk(aad_len_q);
        pt_n        = nblk(pt_len_q);
        last        = rem == LEN_W'(1);
        state_n     = state;
        case (state)
            IDLE:    if (hdr_acc) state_n = J0;
            J0:      if (load) state_n = aad_n != '0 ? AAD : pt_n != '0 ? PT : LEN;
            AAD:     if (blk_acc && last) state_n = pt_n != '0 ? PT : LEN;
            PT:      if (blk_acc && last) state_n = LEN;
            LEN:     if (load) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef GCM_PARTIAL_MASK_EN
    logic [LOG-1:0] tail;
    logic [LOG:0]   tail_bytes;
    // byte 0 sits in the MSBs of the block and maps to mask bit 0
    always_comb begin
        tail       = state == AAD ? aad_len_q[LOG-1:0] : pt_len_q[LOG-1:0];
        tail_bytes = ({1'b0, tail} + (LOG+1)'(7)) >> 3;
        blk_mask   = '1;
        blk_data   = i_blk_data;
        for (int k = 0; k < NB; k++) begin
            blk_mask[k] = !(last && tail != '0) || k < int'(tail_bytes);
            blk_data[BLK_W-1-8*k -: 8] = blk_mask[k] ? i_blk_data[BLK_W-1-8*k -: 8] : 8'h00;
        end
    end
`else
    assign blk_mask = '1;
    assign blk_data = i_blk_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            iv_q       <= '0;
            aad_len_q  <= '0;
            pt_len_q   <= '0;
            rem        <= '0;
            ctr        <= '0;
            o_key      <= '0;
            o_valid    <= 1'b0;
            o_phase    <= '0;
            o_data     <= '0;
            o_ctr      <= '0;
            o_blk_mask <= '0;
            o_last     <= 1'b0;
        end else begin
            if (hdr_acc) begin
                o_key     <= i_cipher_key;
                iv_q      <= i_iv;
                aad_len_q <= i_aad_len;
                pt_len_q  <= i_pt_len;
                ctr       <= CTR_W'(1);
            end
            if (emit && (state == J0 || state == PT)) ctr <= ctr + CTR_W'(1);
            if (state == J0 && load) rem <= aad_n != '0 ? aad_n : pt_n;
            else if (blk_acc) rem <= (state == AAD && last) ? pt_n : rem - LEN_W'(1);
            // a new block replaces the slot in the same cycle it drains
            if (emit) begin
                o_valid    <= 1'b1;
                o_phase    <= state;
                o_last     <= state == LEN;
                o_data     <= state == J0 ? '0 : state == LEN ? {aad_len_q, pt_len_q} : blk_data;
                o_ctr      <= (state == J0 || state == PT) ? {iv_q, ctr} : '0;
                o_blk_mask <= (state == J0 || state == LEN) ? '1 : blk_mask;
            end else if (i_ready) o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_aes_gcm_stage1_seq.sv
// tb_aes_gcm_stage1_seq: directed stimulus with a block-level expected-output queue and literal pins.
module tb_aes_gcm_stage1_seq;
    logic         clk = 1'b0, rst = 1'b1;
    logic         i_new_instance = 1'b0, o_hdr_ready;
    logic [127:0] i_cipher_key = '0;
    logic [95:0]  i_iv = '0;
    logic [63:0]  i_aad_len = '0, i_pt_len = '0;
    logic         i_blk_valid = 1'b0, o_blk_ready;
    logic [127:0] i_blk_data = '0;
    logic         o_valid, i_ready = 1'b1;
    logic [2:0]   o_phase;
    logic [127:0] o_data, o_ctr, o_key;
    logic [15:0]  o_blk_mask;
    logic         o_last;

    typedef struct {
        logic [2:0]   ph;
        logic [127:0] d;
        logic [127:0] c;
        logic [15:0]  m;
        logic         l;
        logic [127:0] k;
    } item_t;

    item_t        q[$], log[$];
    logic [127:0] blks[$];
    int           n_chk = 0, n_pass = 0, run_len = 0, max_run = 0;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [95:0]  IV  = 96'hcafebabefacedbaddecaf888;

    aes_gcm_stage1_seq dut (
        .clk(clk), .rst(rst), .i_new_instance(i_new_instance), .o_hdr_ready(o_hdr_ready),
        .i_cipher_key(i_cipher_key), .i_iv(i_iv), .i_aad_len(i_aad_len), .i_pt_len(i_pt_len),
        .i_blk_valid(i_blk_valid), .o_blk_ready(o_blk_ready), .i_blk_data(i_blk_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_phase(o_phase), .o_data(o_data), .o_ctr(o_ctr),
        .o_blk_mask(o_blk_mask), .o_key(o_key), .o_last(o_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int nb(input logic [63:0] len);
        return int'((len + 64'd127) / 64'd128);
    endfunction

    // expected block sequence of one instance, derived from lengths and streamed data
    task automatic model(input logic [127:0] key, input logic [95:0] iv, input logic [63:0] al, input logic [63:0] pl);
        int na = nb(al), np = nb(pl);
        q.push_back('{3'd1, 128'd0, {iv, 32'd1}, 16'hFFFF, 1'b0, key});
        for (int i = 0; i < na + np; i++) begin
            item_t it = '{i < na ? 3'd2 : 3'd3, blks[i], i < na ? 128'd0 : {iv, 32'(i - na + 2)}, 16'hFFFF, 1'b0, key};
`ifdef GCM_PARTIAL_MASK_EN
            logic [63:0] len = i < na ? al : pl;
            if ((i == na - 1 || i == na + np - 1) && len % 128 != 0) begin
                int nbytes = (int'(len % 128) + 7) / 8;
                it.m = 16'((1 << nbytes) - 1);
                it.d = blks[i] & ({128{1'b1}} << (8 * (16 - nbytes)));
            end
`endif
            q.push_back(it);
        end
        q.push_back('{3'd4, {al, pl}, 128'd0, 16'hFFFF, 1'b1, key});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            run_len = o_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (o_valid && q.size() == 0) begin
                n_chk++;
                $display("FAIL extra_output: got phase %0d data %h expected no output", o_phase, o_data);
            end else if (o_valid) begin
                chk("phase", 128'(o_phase), 128'(q[0].ph));
                chk("data", o_data, q[0].d);
                chk("ctr", o_ctr, q[0].c);
                chk("mask", 128'(o_blk_mask), 128'(q[0].m));
                chk("last", 128'(o_last), 128'(q[0].l));
                chk("key", o_key, q[0].k);
                if (i_ready) begin
                    log.push_back('{o_phase, o_data, o_ctr, o_blk_mask, o_last, o_key});
                    void'(q.pop_front());
                end else chk("blk_ready_stall", 128'(o_blk_ready), 128'd0);
            end
        end
    end

    task automatic send_hdr(input logic [127:0] key, input logic [95:0] iv, input logic [63:0] al, input logic [63:0] pl);
        bit ok = 1'b0;
        i_new_instance = 1'b1; i_cipher_key = key; i_iv = iv; i_aad_len = al; i_pt_len = pl;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = o_hdr_ready;
        end
        chk("hdr_accept_timeout", 128'(ok), 128'd1);
        @(posedge clk); #1;
        i_new_instance = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] d);
        bit ok = 1'b0;
        i_blk_valid = 1'b1; i_blk_data = d;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = o_blk_ready;
        end
        chk("blk_accept_timeout", 128'(ok), 128'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || o_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 128'(q.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [127:0] key, input logic [95:0] iv, input logic [63:0] al,
                       input logic [63:0] pl, input bit stall, input bit zero);
        log.delete();
        blks.delete();
        max_run = 0;
        for (int i = 0; i < nb(al) + nb(pl); i++)
            blks.push_back(zero ? 128'd0 : {$urandom(), $urandom(), $urandom(), $urandom()});
        model(key, iv, al, pl);
        send_hdr(key, iv, al, pl);
        fork
            foreach (blks[i]) send_blk(blks[i]);
            if (stall) begin
                for (int t = 0; t < 100 && !(o_valid && o_phase == 3'd3); t++) @(negedge clk);
                @(posedge clk); #1;
                i_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        i_blk_valid = 1'b0;
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 128'(o_valid), 128'd0);
        chk("rst_phase", 128'(o_phase), 128'd0);
        chk("rst_last", 128'(o_last), 128'd0);
        chk("rst_data", o_data, 128'd0);
        chk("rst_ctr", o_ctr, 128'd0);
        chk("rst_key", o_key, 128'd0);
        chk("rst_mask", 128'(o_blk_mask), 128'd0);
        chk("rst_hdr_ready", 128'(o_hdr_ready), 128'd1);
        chk("rst_blk_ready", 128'(o_blk_ready), 128'd0);
        @(posedge clk); #1;

        run(128'd0, 96'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        chk("empty_count", 128'(log.size()), 128'd2);
        chk("empty_j0_ctr", log[0].c, 128'h1);
        chk("empty_len_phase", 128'(log[1].ph), 128'd4);
        chk("empty_len_data", log[1].d, 128'd0);
        chk("empty_len_last", 128'(log[1].l), 128'd1);

        run(128'd0, 96'd0, 64'd0, 64'd128, 1'b0, 1'b1);
        chk("pt1_count", 128'(log.size()), 128'd3);
        chk("pt1_phase", 128'(log[1].ph), 128'd3);
        chk("pt1_ctr", log[1].c, 128'h2);
        chk("pt1_len", log[2].d, 128'h80);

        run(KEY, IV, 64'd256, 64'd384, 1'b0, 1'b0);
        chk("b2b_valid_run", 128'(max_run), 128'd7);
        chk("b2b_count", 128'(log.size()), 128'd7);
        chk("b2b_ctr2", log[3].c, {IV, 32'd2});
        chk("b2b_ctr3", log[4].c, {IV, 32'd3});
        chk("b2b_ctr4", log[5].c, {IV, 32'd4});

        run(KEY, IV, 64'd256, 64'd384, 1'b1, 1'b0);
        chk("stall_count", 128'(log.size()), 128'd7);
        chk("stall_ctr4", log[5].c, {IV, 32'd4});
        chk("stall_len", log[6].d, {64'd256, 64'd384});

        run(KEY, IV, 64'd0, 64'd480, 1'b0, 1'b0);
`ifdef GCM_PARTIAL_MASK_EN
        chk("tail_mask", 128'(log[4].m), 128'h0FFF);
        chk("tail_bytes_zero", 128'(log[4].d[31:0]), 128'd0);
`else
        chk("tail_mask", 128'(log[4].m), 128'hFFFF);
`endif

        log.delete();
        blks.delete();
        for (int i = 0; i < 3; i++) blks.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        model(KEY, IV, 64'd256, 64'd128);
        send_hdr(KEY, IV, 64'd256, 64'd128);
        send_blk(blks[0]);
        i_blk_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 128'(o_valid), 128'd0);
        chk("midrst_hdr_ready", 128'(o_hdr_ready), 128'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        run(~KEY, ~IV, 64'd128, 64'd128, 1'b0, 1'b0);
        chk("restart_first_phase", 128'(log[0].ph), 128'd1);
        chk("restart_count", 128'(log.size()), 128'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
